// File: rtl/y_mux8_feeder_pkg.sv
// Shared constants and state encoding for the y_mux8_feeder operand stage.
package y_mux8_feeder_pkg;
   localparam int NWORDS = 8;
   localparam int PTR_W  = 3;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/y_mux8_feeder_word_reg.sv
// Single SIZE-bit operand holding register with synchronous clear and load enable.
module y_word_reg #(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            en,
   input  logic [SIZE-1:0] d,
   output logic [SIZE-1:0] q
);
   logic [SIZE-1:0] q_q;
   logic [SIZE-1:0] q_d;

   // Next value: capture d when enabled, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = d;
      end
   end

   // Register with clear taking priority over load.
   always_ff @(posedge clk) begin
      if (clr) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;
endmodule

// File: rtl/y_mux8_feeder.sv
// Operand feeder for yMux8to1: loads eight words serially, then walks the
// mux select through 0..7 one accepted beat at a time, then pulses done.
module y_mux8_feeder
   import y_mux8_feeder_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] in_data,
   output logic [SIZE-1:0] a0,
   output logic [SIZE-1:0] a1,
   output logic [SIZE-1:0] a2,
   output logic [SIZE-1:0] a3,
   output logic [SIZE-1:0] a4,
   output logic [SIZE-1:0] a5,
   output logic [SIZE-1:0] a6,
   output logic [SIZE-1:0] a7,
   output logic [2:0]      c,
   output logic            sel_valid,
   input  logic            sel_ready,
   output logic            done
);
   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   c_q, c_d;
   logic               load_hs;
   logic [SIZE-1:0]    word_q [NWORDS];

   // All handshake-side outputs decode straight from the state register.
   assign in_ready  = (state_q == LOAD);
   assign sel_valid = (state_q == SCAN);
   assign done      = (state_q == DONE);
   assign c         = c_q;
   assign load_hs   = in_ready && in_valid;

   // One holding register per operand; only the slot at wr_ptr loads.
   for (genvar i = 0; i < NWORDS; i++) begin : g_word
      y_word_reg #(.SIZE(SIZE)) u_word (
         .clk (clk),
         .clr (reset),
         .en  (load_hs && (wr_ptr_q == PTR_W'(i))),
         .d   (in_data),
         .q   (word_q[i])
      );
   end

   assign a0 = word_q[0];
   assign a1 = word_q[1];
   assign a2 = word_q[2];
   assign a3 = word_q[3];
   assign a4 = word_q[4];
   assign a5 = word_q[5];
   assign a6 = word_q[6];
   assign a7 = word_q[7];

   // Next-state, write pointer and select counter.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      c_d      = c_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == PTR_W'(NWORDS - 1)) begin
                  state_d = SCAN;
                  c_d     = '0;
               end
            end
         end
         SCAN: begin
            if (sel_ready) begin
               if (c_q == PTR_W'(NWORDS - 1)) begin
                  state_d = DONE;
                  c_d     = '0;
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = LOAD;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Control registers; reset discards any partial load or scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= LOAD;
         wr_ptr_q <= '0;
         c_q      <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         c_q      <= c_d;
      end
   end
endmodule

// File: tb/tb_y_mux8_feeder.sv
// Scoreboard bench for y_mux8_feeder: loads push expected (select, operand)
// pairs, each accepted select beat pops and compares against the mux output.
module tb_y_mux8_feeder;
   localparam int SIZE = 32;

   typedef struct packed {
      logic [2:0]      c;
      logic [SIZE-1:0] v;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [SIZE-1:0] in_data;
   logic [SIZE-1:0] a0, a1, a2, a3, a4, a5, a6, a7;
   logic [2:0]      c;
   logic            sel_valid;
   logic            sel_ready;
   logic            done;

   logic [SIZE-1:0] a_dut [8];
   logic [SIZE-1:0] z;
   logic [SIZE-1:0] model_a [8];
   int              model_ptr;
   exp_t            exp_q [$];
   int              checks = 0;
   int              errors = 0;
   int              done_cnt = 0;

   y_mux8_feeder #(.SIZE(SIZE)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .a0        (a0),
      .a1        (a1),
      .a2        (a2),
      .a3        (a3),
      .a4        (a4),
      .a5        (a5),
      .a6        (a6),
      .a7        (a7),
      .c         (c),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .done      (done)
   );

   always #5 clk = ~clk;

   assign a_dut[0] = a0;
   assign a_dut[1] = a1;
   assign a_dut[2] = a2;
   assign a_dut[3] = a3;
   assign a_dut[4] = a4;
   assign a_dut[5] = a5;
   assign a_dut[6] = a6;
   assign a_dut[7] = a7;
   // Stand-in for the downstream yMux8to1.
   assign z = a_dut[c];

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      sel_ready = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) model_a[i] = '0;
      model_ptr = 0;
      exp_q.delete();
   endtask

   // Offer one word and wait (bounded) for it to be accepted.
   task automatic load_word(input logic [SIZE-1:0] d);
      bit got = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 20 && !got; i++) begin
         got = in_ready;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL load_timeout got in_ready=0 required 1");
      end else begin
         model_a[model_ptr] = d;
         model_ptr = (model_ptr + 1) % 8;
         if (model_ptr == 0) begin
            for (int k = 0; k < 8; k++) exp_q.push_back('{c: 3'(k), v: model_a[k]});
         end
      end
   endtask

   // Take one select beat; report what was presented and how long it waited.
   task automatic take_beat(output logic [2:0] oc, output logic [SIZE-1:0] oz,
                            output int waited, output bit ok);
      ok = 0;
      waited = 0;
      oc = '0;
      oz = '0;
      sel_ready = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (sel_valid) begin
            oc = c;
            oz = z;
            waited = i;
            ok = 1;
         end
         tick();
      end
      sel_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      checks++;
      if ({in_ready, sel_valid, done, c} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b sv=%b done=%b c=%0d required 1 0 0 0", in_ready, sel_valid, done, c);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (a_dut[i] !== '0) begin
            errors++;
            $display("FAIL reset_a%0d got %h required 0", i, a_dut[i]);
         end
      end
   endtask

   task automatic test_basic();
      logic [2:0] oc; logic [SIZE-1:0] oz; int w; bit ok; exp_t e; int d0;
      do_reset();
      for (int k = 1; k <= 8; k++) load_word(SIZE'(11 * k));
      checks++;
      if ({in_ready, sel_valid, c} !== {1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL basic_enter_scan got rdy=%b sv=%b c=%0d required 0 1 0", in_ready, sel_valid, c);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (a_dut[i] !== SIZE'(11 * (i + 1))) begin
            errors++;
            $display("FAIL basic_a%0d got %0d required %0d", i, a_dut[i], 11 * (i + 1));
         end
      end
      d0 = done_cnt;
      for (int b = 0; b < 8; b++) begin
         take_beat(oc, oz, w, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || w != 0 || oc !== e.c || oz !== e.v) begin
            errors++;
            $display("FAIL basic_beat%0d got c=%0d z=%0d wait=%0d ok=%0d required c=%0d z=%0d wait=0", b, oc, oz, w, ok, e.c, e.v);
         end
      end
      checks++;
      if ({done, sel_valid, in_ready} !== 3'b100) begin
         errors++;
         $display("FAIL basic_done got done=%b sv=%b rdy=%b required 1 0 0", done, sel_valid, in_ready);
      end
      tick();
      checks++;
      if ({done, in_ready} !== 2'b01 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL basic_reload got done=%b rdy=%b pulses=%0d required 0 1 1", done, in_ready, done_cnt - d0);
      end
   endtask

   task automatic test_gaps();
      logic [2:0] oc; logic [SIZE-1:0] oz; int w; bit ok; exp_t e;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         load_word(SIZE'(11 * k));
         tick();
         checks++;
         if (k < 8 && (sel_valid !== 1'b0 || in_ready !== 1'b1)) begin
            errors++;
            $display("FAIL gaps_early_scan word%0d got sv=%b rdy=%b required 0 1", k, sel_valid, in_ready);
         end else if (k == 8 && sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL gaps_scan got sv=%b required 1", sel_valid);
         end
      end
      for (int b = 0; b < 8; b++) begin
         take_beat(oc, oz, w, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || oc !== e.c || oz !== e.v) begin
            errors++;
            $display("FAIL gaps_beat%0d got c=%0d z=%0d required c=%0d z=%0d", b, oc, oz, e.c, e.v);
         end
      end
   endtask

   task automatic test_stall();
      logic [2:0] oc; logic [SIZE-1:0] oz; int w; bit ok; exp_t e;
      do_reset();
      for (int k = 0; k < 8; k++) load_word(32'hA000_0000 + SIZE'(k * 7));
      for (int b = 0; b < 8; b++) begin
         if (b == 3) begin
            for (int s = 0; s < 5; s++) begin
               tick();
               checks++;
               if (c !== 3'd3 || sel_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_hold cyc%0d got c=%0d sv=%b required 3 1", s, c, sel_valid);
               end
               for (int i = 0; i < 8; i++) begin
                  checks++;
                  if (a_dut[i] !== model_a[i]) begin
                     errors++;
                     $display("FAIL stall_a%0d got %h required %h", i, a_dut[i], model_a[i]);
                  end
               end
            end
         end
         take_beat(oc, oz, w, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || oc !== e.c || oz !== e.v) begin
            errors++;
            $display("FAIL stall_beat%0d got c=%0d z=%h required c=%0d z=%h", b, oc, oz, e.c, e.v);
         end
      end
   endtask

   task automatic test_ignore();
      logic [2:0] oc; logic [SIZE-1:0] oz; int w; bit ok; exp_t e;
      do_reset();
      for (int k = 0; k < 8; k++) load_word(32'h5000_0000 + SIZE'(k));
      in_valid = 1'b1;
      in_data  = 32'h0000_DEAD;
      for (int b = 0; b < 8; b++) begin
         take_beat(oc, oz, w, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || oc !== e.c || oz !== e.v) begin
            errors++;
            $display("FAIL ignore_beat%0d got c=%0d z=%h required c=%0d z=%h", b, oc, oz, e.c, e.v);
         end
      end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (a_dut[i] !== model_a[i]) begin
            errors++;
            $display("FAIL ignore_a%0d got %h required %h", i, a_dut[i], model_a[i]);
         end
      end
      load_word(32'h0000_1234);
      checks++;
      if (a0 !== 32'h0000_1234 || a1 !== model_a[1]) begin
         errors++;
         $display("FAIL ignore_first_slot got a0=%h a1=%h required 00001234 %h", a0, a1, model_a[1]);
      end
   endtask

   task automatic test_mid_reset();
      logic [2:0] oc; logic [SIZE-1:0] oz; int w; bit ok; exp_t e;
      for (int phase = 0; phase < 2; phase++) begin
         do_reset();
         if (phase == 0) begin
            for (int k = 0; k < 5; k++) load_word(32'h7700_0000 + SIZE'(k + 1));
         end else begin
            for (int k = 0; k < 8; k++) load_word(32'h6600_0000 + SIZE'(k + 1));
            for (int b = 0; b < 6; b++) begin
               take_beat(oc, oz, w, ok);
               e = exp_q.pop_front();
               checks++;
               if (!ok || oc !== e.c || oz !== e.v) begin
                  errors++;
                  $display("FAIL midrst_beat%0d got c=%0d z=%h required c=%0d z=%h", b, oc, oz, e.c, e.v);
               end
            end
            checks++;
            if (c !== 3'd6) begin
               errors++;
               $display("FAIL midrst_c6 got c=%0d required 6", c);
            end
         end
         do_reset();
         checks++;
         if ({in_ready, sel_valid, done, c} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midrst%0d_ctrl got rdy=%b sv=%b done=%b c=%0d required 1 0 0 0", phase, in_ready, sel_valid, done, c);
         end
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_dut[i] !== '0) begin
               errors++;
               $display("FAIL midrst%0d_a%0d got %h required 0", phase, i, a_dut[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] oc; logic [SIZE-1:0] oz; int w; bit ok; exp_t e; int d0;
      logic [SIZE-1:0] pat;
      do_reset();
      d0 = done_cnt;
      for (int r = 0; r < 2; r++) begin
         pat = (r == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
         for (int k = 0; k < 8; k++) load_word(pat);
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_dut[i] !== pat) begin
               errors++;
               $display("FAIL b2b%0d_a%0d got %h required %h", r, i, a_dut[i], pat);
            end
         end
         for (int b = 0; b < 8; b++) begin
            take_beat(oc, oz, w, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || oc !== e.c || oz !== e.v) begin
               errors++;
               $display("FAIL b2b%0d_beat%0d got c=%0d z=%h required c=%0d z=%h", r, b, oc, oz, e.c, e.v);
            end
         end
      end
      tick();
      checks++;
      if (done_cnt - d0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_done_pulses got %0d left=%0d required 2 0", done_cnt - d0, exp_q.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      sel_ready = 1'b0;
      model_ptr = 0;
      tick();
      test_reset();
      test_basic();
      test_gaps();
      test_stall();
      test_ignore();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
